// File: rtl/masked_m2l_scatter.sv
// Scatters a packed, in-order byte stream onto the byte lanes selected by a per-beat
// write mask, producing lane-aligned data + mask beats behind a single output register.
module masked_m2l_scatter #(
  parameter int W        = 8,
  parameter int BYTE_BIT = 8,
  localparam int CW      = $clog2(W+1),
  localparam int LW      = $clog2(2*W+1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [W-1:0][BYTE_BIT-1:0] i_in_data,
  input  logic [CW-1:0]              i_in_count,
  input  logic                       i_mask_valid,
  output logic                       o_mask_ready,
  input  logic [W-1:0]               i_mask_in,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [W-1:0][BYTE_BIT-1:0] o_out_data,
  output logic [W-1:0]               o_out_mask
);

  logic [2*W-1:0][BYTE_BIT-1:0] r_buf, w_buf_nxt;
  logic [LW-1:0]                r_lvl, w_lvl_nxt;
  logic                         r_out_valid;
  logic [W-1:0][BYTE_BIT-1:0]   r_out_data, w_scat;
  logic [W-1:0]                 r_out_mask;
  int                           w_pc, w_pop, w_cnt, w_base;
  logic                         w_push, w_mfire;

  always_comb begin
    w_pc = 0;
    for (int i = 0; i < W; i++) w_pc += i_mask_in[i] ? 1 : 0;
  end

  assign o_in_ready   = (r_lvl <= LW'(W));
  assign o_mask_ready = (int'(r_lvl) >= w_pc) && (!r_out_valid || i_out_ready);
  assign w_push       = i_in_valid && o_in_ready;
  assign w_mfire      = i_mask_valid && o_mask_ready;

  // Lane i takes the k-th oldest byte, k = number of enabled lanes below it.
  always_comb begin
    int k;
    k      = 0;
    w_scat = '0;
    for (int i = 0; i < W; i++) begin
      if (i_mask_in[i]) begin
        w_scat[i] = r_buf[k];
        k         = k + 1;
      end
    end
  end

  // Pop first (shift down), then append the new bytes right after the survivors.
  always_comb begin
    w_pop  = w_mfire ? w_pc : 0;
    w_cnt  = 0;
    if (w_push) w_cnt = (int'(i_in_count) > W) ? W : int'(i_in_count);
    w_base = int'(r_lvl) - w_pop;
    for (int j = 0; j < 2*W; j++)
      w_buf_nxt[j] = (j + w_pop < 2*W) ? r_buf[j+w_pop] : '0;
    for (int j = 0; j < 2*W; j++)
      if (j >= w_base && j < w_base + w_cnt) w_buf_nxt[j] = i_in_data[j-w_base];
    w_lvl_nxt = LW'(w_base + w_cnt);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf       <= '0;
      r_lvl       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_mask  <= '0;
    end else begin
      r_buf <= w_buf_nxt;
      r_lvl <= w_lvl_nxt;
      if (w_mfire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_scat;
        r_out_mask  <= i_mask_in;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_mask  = r_out_mask;

endmodule

// File: doc/masked_m2l_scatter.md
# masked_m2l_scatter

Sequential inverse of the masked lane-to-memory compactor. It buffers a stream of packed bytes, contiguous from byte 0, and scatters them onto the byte lanes selected by a per-beat write mask. The output is a lane-aligned data word plus mask, ready for the TL-UL memory write/response path. Bytes are consumed strictly in arrival order, so a packed stream is expanded back into masked lane format.

## Interface
- W, 8, lanes per beat (mask width)
- BYTE_BIT, 8, bits per byte lane
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset; synchronous, active-high
- IN_VALID  in  1  packed word offered
- IN_READY  out  1  high when level <= W
- IN_DATA  in  W*BYTE_BIT  packed bytes; byte 0 at bits [BYTE_BIT-1:0]
- IN_COUNT  in  $clog2(W+1)  number of valid low bytes in IN_DATA (0..W)
- MASK_VALID  in  1  scatter request offered
- MASK_READY  out  1  request can be accepted this cycle (see Operation)
- MASK_IN  in  W  lane mask for the requested beat
- OUT_VALID  out  1  scattered beat held in output register
- OUT_READY  in  1  consumer accepts beat
- OUT_DATA  out  W*BYTE_BIT  lane-aligned data; unmasked lanes are zero
- OUT_MASK  out  W  copy of the MASK_IN that produced OUT_DATA

## Operation
- Byte buffer: 2W bytes, with level counter LVL (width $clog2(2W+1), range 0..2W). Buffer byte 0 is the oldest byte.
- PUSH = IN_VALID & IN_READY.
  - IN_READY = (LVL <= W), derived combinationally from the registered LVL only.
  - Pushed bytes are written at position LVL-POP.
  - IN_COUNT > W is clamped to W. IN_COUNT = 0 is a legal handshake with no state change.
- PC = popcount(MASK_IN).
- MASK_READY = (LVL >= PC) & (!OUT_VALID | OUT_READY).
  - MASK_READY depends on MASK_IN combinationally; the sender holds MASK_IN stable while MASK_VALID is high.
  - MFIRE = MASK_VALID & MASK_READY.
- On MFIRE:
  - Lane i of the next OUT_DATA = buffer byte k, where k = number of set MASK_IN bits below i, if MASK_IN[i] = 1; otherwise zero.
  - OUT_MASK <= MASK_IN, OUT_VALID <= 1.
  - POP = PC; the buffer shifts down by POP bytes.
- Without MFIRE, POP = 0. If OUT_VALID & OUT_READY, then OUT_VALID <= 0.
- Simultaneous PUSH and MFIRE:
  - The scatter uses pre-push buffer contents.
  - Buffer update is pop first, then append.
  - LVL_next = LVL - POP + clamp(IN_COUNT).
  - Bytes pushed in cycle t are usable for scatter in cycle t+1 at the earliest; there is no bypass.
- MASK_IN = 0: fires whenever the output register is free, regardless of LVL. Emits OUT_DATA = 0, OUT_MASK = 0 and consumes nothing.
- Buffer bytes at or above LVL are don't-care internally, but they never reach OUT_DATA.
- Reset: LVL = 0, buffer cleared, OUT_VALID = 0, OUT_DATA = 0, OUT_MASK = 0. As a result IN_READY = 1 and MASK_READY = 1 only for MASK_IN = 0.
- Reset mid-operation discards buffered bytes and any pending output beat. Nothing is emitted during the reset cycle.

## Timing
- Mask-to-output latency: 1 cycle. OUT_VALID rises on the edge that samples MFIRE.
- Full throughput: one beat per cycle while OUT_READY = 1 and LVL covers PC. Back-to-back MFIRE is allowed when OUT_READY = 1 in the same cycle.
- OUT_DATA and OUT_MASK hold stable while OUT_VALID & !OUT_READY.
- Input-to-availability latency: 1 cycle. A push in cycle t counts in LVL from cycle t+1.
- IN_READY and MASK_READY have no combinational path from OUT_VALID of a downstream stage beyond OUT_READY itself. The only combinational paths are OUT_READY -> MASK_READY and MASK_IN -> MASK_READY.
- LVL never exceeds 2W: a push requires LVL <= W and adds at most W.

## Test plan
- Reset then single push: IN_DATA = 0x..0807060504030201, IN_COUNT = 8, then MASK_IN = 0xFF -> next cycle OUT_DATA = 0x0807060504030201, OUT_MASK = 0xFF, LVL = 0.
- Sparse scatter: push bytes 0x11, 0x22, 0x33 (IN_COUNT = 3), then MASK_IN = 0b10010010 -> OUT_DATA lane 1 = 0x11, lane 4 = 0x22, lane 7 = 0x33, all other lanes 0.
- Insufficient data: LVL = 2, MASK_IN = 0x0F -> MASK_READY = 0. The request stalls until a push raises LVL to at least 4, then fires one cycle after that push.
- Backpressure: OUT_READY = 0 with OUT_VALID = 1 -> MASK_READY = 0, and OUT_DATA/OUT_MASK hold for 5 cycles. On OUT_READY = 1, a pending mask fires in the same cycle.
- Simultaneous push and pop at LVL = 8: MASK_IN = 0x0F fires while a push of IN_COUNT = 8 occurs -> LVL = 12. Output uses the old bytes 0..3, and the pushed bytes follow the old bytes 4..7 in order. IN_READY = 0 at LVL = 12.
- Edge cases: MASK_IN = 0 at LVL = 0 -> zero beat emitted. IN_COUNT = 0 push -> LVL unchanged. RST asserted with LVL = 10 and OUT_VALID = 1 -> all outputs 0 and LVL = 0 the next cycle.
